// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with normal or show-ahead read, almost-full,
// overflow/underflow pulses and a 0..DEPTH used-word count. Optional macro PARAM_FIFO_STATS_EN adds a high-water mark.
module param_sync_fifo #(
  parameter int WIDTH             = 64,
  parameter int DEPTH_LOG2        = 8,
  parameter int SHOWAHEAD         = 0,
  parameter int ALMOST_FULL_LEVEL = (2 ** DEPTH_LOG2) - 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sclr,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DEPTH_LOG2:0]   max_usedw
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  // A level above DEPTH can never be reached; a negative level is always met.
  localparam bit AF_NEVER = (ALMOST_FULL_LEVEL > DEPTH);
  localparam int AF_CLAMP = (ALMOST_FULL_LEVEL < 0) ? 0 :
                            (AF_NEVER ? DEPTH : ALMOST_FULL_LEVEL);
  localparam logic [DEPTH_LOG2:0] AF_LVL = (DEPTH_LOG2 + 1)'(AF_CLAMP);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      q_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   usedw_q, usedw_d;
  logic                  empty_q, full_q, af_q, af_d;
  logic                  ovf_q, udf_q;
  logic                  rd_ok, wr_ok, wr_en;

  always_comb begin
    rd_ok    = rdreq && !empty_q;
    wr_ok    = wrreq && (!full_q || rd_ok);
    wr_en    = wr_ok && !sclr;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    usedw_d  = usedw_q;
    case ({wr_ok, rd_ok})
      2'b10:   usedw_d = usedw_q + 1'b1;
      2'b01:   usedw_d = usedw_q - 1'b1;
      default: usedw_d = usedw_q;
    endcase
    af_d = !AF_NEVER && (usedw_d >= AF_LVL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= (usedw_d == '0);
      full_q   <= (usedw_d == DEPTH_CNT);
      af_q     <= af_d;
      ovf_q    <= wrreq && !wr_ok;
      udf_q    <= rdreq && !rd_ok;
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    // Registered read at the next head address; bypass covers the word being
    // written this edge when it becomes the head (write into empty/last word).
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q_q <= '0;
      end else if (sclr) begin
        q_q <= '0;
      end else if (usedw_d == '0) begin
        q_q <= '0;
      end else if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
        q_q <= data;
      end else begin
        q_q <= mem_q[rd_ptr_d];
      end
    end
  end else begin : g_normal
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q_q <= '0;
      end else if (sclr) begin
        q_q <= '0;
      end else if (rd_ok) begin
        q_q <= mem_q[rd_ptr_q];
      end
    end
  end

`ifdef PARAM_FIFO_STATS_EN
  logic [DEPTH_LOG2:0] max_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      max_q <= '0;
    end else if (sclr) begin
      max_q <= '0;
    end else if (usedw_d > max_q) begin
      max_q <= usedw_d;
    end
  end

  assign max_usedw = max_q;
`else
  assign max_usedw = '0;
`endif

  assign q           = q_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign usedw       = usedw_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule
